// File: rtl/ad9866_pkg.sv
// ----------------------------------------------------------------------------
// ad9866_pkg
// Shared widths and the arbiter state encoding for the AD9866 command path.
// ----------------------------------------------------------------------------
package ad9866_pkg;

  localparam int CMD_ADDR_W = 6;
  localparam int CMD_DATA_W = 32;
  localparam int GRANT_W    = 3;   // wide enough for up to 8 requesters

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DONE  = 2'd2,
    ARB_ABORT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ad9866_rr_pick.sv
// ----------------------------------------------------------------------------
// ad9866_rr_pick
// Combinational round-robin picker: returns the first set bit of rqst found
// scanning upward from ptr and wrapping NREQ-1 -> 0.
// Ports:
//   rqst   in  NREQ  request vector
//   ptr    in  3     scan start index (always < NREQ)
//   valid  out 1     at least one request set
//   winner out 3     index of the chosen requester (0 when valid is low)
// ----------------------------------------------------------------------------
module ad9866_rr_pick
  import ad9866_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]    rqst,
  input  logic [GRANT_W-1:0] ptr,
  output logic               valid,
  output logic [GRANT_W-1:0] winner
);

  // Scan from the farthest offset back to the pointer so the closest hit wins.
  always_comb begin
    valid  = 1'b0;
    winner = {GRANT_W{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (rqst[idx]) begin
        valid  = 1'b1;
        winner = GRANT_W'(idx);
      end else begin
        valid  = valid;
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/ad9866_cmd_arb.sv
// ----------------------------------------------------------------------------
// ad9866_cmd_arb
// Round-robin arbiter sharing one AD9866 command slave among NREQ requesters.
// The winning request is latched in IDLE, presented to the slave while in
// ISSUE, and either completed (one-cycle req_ack to the winner) or aborted
// after TIMEOUT cycles without m_cmd_ack (one-cycle timeout_err).
// Optional build macro AD9866_ARB_PRIO0_EN: requester 0 gets fixed highest
// priority and round robin covers requesters 1..NREQ-1 only.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_addr      in  6*NREQ   per-requester address, slice i = [6*i+:6]
//   req_data      in  32*NREQ  per-requester data, slice i = [32*i+:32]
//   req_rqst      in  NREQ     per-requester request level
//   req_ack       out NREQ     one-cycle completion pulse to the winner
//   m_cmd_addr    out 6        to command slave
//   m_cmd_data    out 32       to command slave
//   m_cmd_rqst    out 1        request to command slave
//   m_cmd_ack     in  1        slave accept
//   grant_id      out 3        index of current or last grant
//   busy          out 1        high whenever not IDLE
//   timeout_err   out 1        one-cycle pulse on abort
// ----------------------------------------------------------------------------
module ad9866_cmd_arb
  import ad9866_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CMD_ADDR_W*NREQ-1:0] req_addr,
  input  logic [CMD_DATA_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]            req_rqst,
  output logic [NREQ-1:0]            req_ack,
  output logic [CMD_ADDR_W-1:0]      m_cmd_addr,
  output logic [CMD_DATA_W-1:0]      m_cmd_data,
  output logic                       m_cmd_rqst,
  input  logic                       m_cmd_ack,
  output logic [GRANT_W-1:0]         grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t            state_r;
  arb_state_t            state_nxt_s;
  logic [TW-1:0]         timer_r;
  logic [GRANT_W-1:0]    ptr_r;
  logic [GRANT_W-1:0]    grant_r;
  logic [CMD_ADDR_W-1:0] addr_r;
  logic [CMD_DATA_W-1:0] data_r;
  logic                  rqst_r;
  logic [NREQ-1:0]       ack_r;
  logic                  terr_r;
  logic                  busy_r;

  logic [NREQ-1:0]       pick_rqst_s;
  logic                  pick_valid_s;
  logic [GRANT_W-1:0]    pick_idx_s;
  logic                  win_valid_s;
  logic [GRANT_W-1:0]    win_idx_s;
  logic                  ptr_upd_s;
  logic                  grant_s;

  ad9866_rr_pick #(.NREQ(NREQ)) u_pick (
    .rqst   (pick_rqst_s),
    .ptr    (ptr_r),
    .valid  (pick_valid_s),
    .winner (pick_idx_s)
  );

`ifdef AD9866_ARB_PRIO0_EN
  // Requester 0 overrides the round-robin result and leaves the pointer alone.
  always_comb begin
    pick_rqst_s = req_rqst & ~NREQ'(1'b1);
    win_valid_s = req_rqst[0] | pick_valid_s;
    if (req_rqst[0]) begin
      win_idx_s = {GRANT_W{1'b0}};
      ptr_upd_s = 1'b0;
    end else begin
      win_idx_s = pick_idx_s;
      ptr_upd_s = 1'b1;
    end
  end
`else
  // Pure round robin across every requester.
  always_comb begin
    pick_rqst_s = req_rqst;
    win_valid_s = pick_valid_s;
    win_idx_s   = pick_idx_s;
    ptr_upd_s   = 1'b1;
  end
`endif

  assign grant_s = (state_r == ARB_IDLE) && win_valid_s;

  // Next-state decode; an ack in the expiry cycle still counts as completion.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (win_valid_s) state_nxt_s = ARB_ISSUE;
        else             state_nxt_s = ARB_IDLE;
      end
      ARB_ISSUE: begin
        if (m_cmd_ack)                          state_nxt_s = ARB_DONE;
        else if (timer_r == TW'(TIMEOUT - 1))   state_nxt_s = ARB_ABORT;
        else                                    state_nxt_s = ARB_ISSUE;
      end
      ARB_DONE:  state_nxt_s = ARB_IDLE;
      ARB_ABORT: state_nxt_s = ARB_IDLE;
      default:   state_nxt_s = ARB_IDLE;
    endcase
  end

  // State register plus output flops decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
      rqst_r  <= 1'b0;
      busy_r  <= 1'b0;
      terr_r  <= 1'b0;
      ack_r   <= {NREQ{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      rqst_r  <= (state_nxt_s == ARB_ISSUE);
      busy_r  <= (state_nxt_s != ARB_IDLE);
      terr_r  <= (state_nxt_s == ARB_ABORT);
      if (state_nxt_s == ARB_DONE) ack_r <= NREQ'(1'b1) << grant_r;
      else                         ack_r <= {NREQ{1'b0}};
    end
  end

  // Grant latch: winner's command, grant index and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= {CMD_ADDR_W{1'b0}};
      data_r  <= {CMD_DATA_W{1'b0}};
      grant_r <= {GRANT_W{1'b0}};
      ptr_r   <= {GRANT_W{1'b0}};
    end else if (grant_s) begin
      addr_r  <= req_addr[CMD_ADDR_W*win_idx_s +: CMD_ADDR_W];
      data_r  <= req_data[CMD_DATA_W*win_idx_s +: CMD_DATA_W];
      grant_r <= win_idx_s;
      if (ptr_upd_s) begin
        if (win_idx_s == GRANT_W'(NREQ - 1)) ptr_r <= {GRANT_W{1'b0}};
        else                                 ptr_r <= win_idx_s + 3'd1;
      end
    end
  end

  // Transaction timer: cleared on grant, counts in ISSUE, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r <= {TW{1'b0}};
    end else if (grant_s) begin
      timer_r <= {TW{1'b0}};
    end else if ((state_r == ARB_ISSUE) && (timer_r != {TW{1'b1}})) begin
      timer_r <= timer_r + TW'(1);
    end
  end

  assign m_cmd_addr  = addr_r;
  assign m_cmd_data  = data_r;
  assign m_cmd_rqst  = rqst_r;
  assign req_ack     = ack_r;
  assign grant_id    = grant_r;
  assign busy        = busy_r;
  assign timeout_err = terr_r;

endmodule
